// File: rtl/cc_pkg.sv
// Shared cache-controller response definitions: line/offset widths, FIFO entry layout, scheduler FSM states.
package cc_pkg;

    localparam int CC_LINE_W = 512;
    localparam int CC_OFF_W  = 6;
    localparam int CC_FIFO_W = CC_OFF_W + CC_LINE_W;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } cc_resp_state_t;

    // The serializer reads offset[5:3] (entry bits [517:515]) as its starting beat.
    typedef struct packed {
        logic [CC_OFF_W-1:0]  offset;
        logic [CC_LINE_W-1:0] line;
    } cc_fifo_entry_t;

    function automatic cc_fifo_entry_t cc_pack(input logic [CC_OFF_W-1:0]  offset,
                                               input logic [CC_LINE_W-1:0] line);
        cc_fifo_entry_t e;
        e.offset = offset;
        e.line   = line;
        return e;
    endfunction

endpackage

// File: rtl/cc_resp_sched_if.sv
// Request, serializer-FIFO and snoop signals of the response scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface cc_resp_sched_if;

    logic                       hit_valid_i;
    logic                       hit_ready_o;
    logic [cc_pkg::CC_OFF_W-1:0]  hit_offset_i;
    logic [cc_pkg::CC_LINE_W-1:0] hit_data_i;

    logic                       miss_valid_i;
    logic                       miss_ready_o;
    logic [cc_pkg::CC_OFF_W-1:0]  miss_offset_i;
    logic [cc_pkg::CC_LINE_W-1:0] miss_data_i;

    logic                       fifo_full_i;
    logic                       fifo_afull_i;
    logic                       fifo_wren_o;
    logic [cc_pkg::CC_FIFO_W-1:0] fifo_wdata_o;

    logic                       rvalid_i;
    logic                       rready_i;
    logic                       rlast_i;

    logic                       flush_i;
    logic                       flush_done_o;
    logic [3:0]                 outstanding_o;
    logic                       err_o;

    modport slave (
        input  hit_valid_i, hit_offset_i, hit_data_i,
        output hit_ready_o,
        input  miss_valid_i, miss_offset_i, miss_data_i,
        output miss_ready_o,
        input  fifo_full_i, fifo_afull_i,
        output fifo_wren_o, fifo_wdata_o,
        input  rvalid_i, rready_i, rlast_i,
        input  flush_i,
        output flush_done_o, outstanding_o, err_o
    );

    modport master (
        output hit_valid_i, hit_offset_i, hit_data_i,
        input  hit_ready_o,
        output miss_valid_i, miss_offset_i, miss_data_i,
        input  miss_ready_o,
        output fifo_full_i, fifo_afull_i,
        input  fifo_wren_o, fifo_wdata_o,
        output rvalid_i, rready_i, rlast_i,
        output flush_i,
        input  flush_done_o, outstanding_o, err_o
    );

endinterface

// File: rtl/cc_resp_arb2.sv
// Two-requester grant (hit vs miss-fill), purely combinational grant; grants only valid requesters.
// CC_RESP_RR_EN: round-robin with a last-grant bit; otherwise fixed priority miss over hit.
module cc_resp_arb2 (
`ifdef CC_RESP_RR_EN
    input  logic clk,
    input  logic rst_n,
    input  logic xfer,
`endif
    input  logic req_hit,
    input  logic req_miss,
    output logic gnt_hit,
    output logic gnt_miss
);

`ifdef CC_RESP_RR_EN
    logic last_miss_q;

    // Reset points at hit, so miss wins the first contention.
    always_comb begin
        gnt_miss = req_miss && (!req_hit || !last_miss_q);
        gnt_hit  = req_hit && !gnt_miss;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_miss_q <= 1'b0;
        else if (xfer)
            last_miss_q <= gnt_miss;
    end
`else
    always_comb begin
        gnt_miss = req_miss;
        gnt_hit  = req_hit && !req_miss;
    end
`endif

endmodule

// File: rtl/cc_resp_sched.sv
// Response scheduler: arbitrates hit/miss lines into the 518-bit serializer FIFO entry, limits lines in flight.
// Latency: accept -> fifo_wren_o one cycle, one line per cycle; readies drop on FIFO full/afull, credit limit or flush.
// Optional round-robin arbitration via CC_RESP_RR_EN (fixed miss-over-hit when undefined).
module cc_resp_sched
    import cc_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cc_resp_sched_if.slave   bus
);

    cc_resp_state_t        state_q, state_d;
    logic [3:0]            out_q;
    logic                  wren_q;
    logic [CC_FIFO_W-1:0]  wdata_q;
    logic                  err_q;
    logic                  flush_done_q;

    logic                  gnt_hit, gnt_miss;
    logic                  can_accept;
    logic                  hit_xfer, miss_xfer, any_xfer;
    logic                  ret;
    logic [4:0]            inflight;

    cc_resp_arb2 u_arb (
`ifdef CC_RESP_RR_EN
        .clk      (clk),
        .rst_n    (rst_n),
        .xfer     (any_xfer),
`endif
        .req_hit  (bus.hit_valid_i),
        .req_miss (bus.miss_valid_i),
        .gnt_hit  (gnt_hit),
        .gnt_miss (gnt_miss)
    );

    // A push already registered but not yet counted still consumes a credit.
    assign inflight = {1'b0, out_q} + {4'd0, wren_q};

    always_comb begin
        can_accept = rst_n && (state_q == RUN) && !bus.flush_i && !bus.fifo_full_i
                     && !(bus.fifo_afull_i && wren_q) && (inflight < 5'(MAX_OUT));
    end

    assign bus.hit_ready_o  = can_accept && gnt_hit;
    assign bus.miss_ready_o = can_accept && gnt_miss;

    assign hit_xfer  = bus.hit_valid_i  && bus.hit_ready_o;
    assign miss_xfer = bus.miss_valid_i && bus.miss_ready_o;
    assign any_xfer  = hit_xfer || miss_xfer;
    assign ret       = bus.rvalid_i && bus.rready_i && bus.rlast_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wren_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            wren_q <= any_xfer;
            if (miss_xfer)
                wdata_q <= cc_pack(bus.miss_offset_i, bus.miss_data_i);
            else if (hit_xfer)
                wdata_q <= cc_pack(bus.hit_offset_i, bus.hit_data_i);
        end
    end

    // Completion with nothing in flight is a protocol error: hold at zero and flag it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 4'd0;
            err_q <= 1'b0;
        end else if (wren_q && !ret) begin
            out_q <= out_q + 4'd1;
        end else if (ret && !wren_q) begin
            if (out_q == 4'd0)
                err_q <= 1'b1;
            else
                out_q <= out_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= (state_q == DRAIN) && (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.flush_i) state_d = DRAIN;
            DRAIN:   if ((out_q == 4'd0) && !wren_q) state_d = DONE;
            DONE:    if (!bus.flush_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign bus.fifo_wren_o   = wren_q;
    assign bus.fifo_wdata_o  = wdata_q;
    assign bus.outstanding_o = out_q;
    assign bus.err_o         = err_q;
    assign bus.flush_done_o  = flush_done_q;

endmodule

// File: tb/tb_cc_resp_sched.sv
// Bench for cc_resp_sched: a credit/flush model checked every cycle plus directed literal expectations.
module tb_cc_resp_sched;
    import cc_pkg::*;

    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cc_resp_sched_if bus ();

    cc_resp_sched #(.MAX_OUT(MAX_OUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [517:0] act, input logic [517:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mkline(input logic [63:0] base);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[k*64 +: 64] = base + 64'(k);
        return r;
    endfunction

    // ---------------- model: lines in flight, queued write, drain mode ----------------
    int            m_out;
    bit            m_wren;
    logic [517:0]  m_wdata;
    bit            m_err;
    int            m_mode;      // 0 accepting, 1 draining, 2 drained
    bit            m_done;
    bit            m_last_miss;
    logic          e_can, e_win_miss, e_hit_rdy, e_miss_rdy, e_ret;

    always_comb begin
        e_can = rst_n && (m_mode == 0) && !bus.flush_i && !bus.fifo_full_i
                && !(bus.fifo_afull_i && m_wren) && ((m_out + int'(m_wren)) < MAX_OUT);
`ifdef CC_RESP_RR_EN
        e_win_miss = bus.miss_valid_i && (!bus.hit_valid_i || !m_last_miss);
`else
        e_win_miss = bus.miss_valid_i;
`endif
        e_miss_rdy = e_can && e_win_miss;
        e_hit_rdy  = e_can && bus.hit_valid_i && !e_win_miss;
        e_ret      = bus.rvalid_i && bus.rready_i && bus.rlast_i;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out <= 0; m_wren <= 0; m_wdata <= '0; m_err <= 0;
            m_mode <= 0; m_done <= 0; m_last_miss <= 0;
        end else begin
            m_wren <= e_miss_rdy || e_hit_rdy;
            if (e_miss_rdy)     m_wdata <= {bus.miss_offset_i, bus.miss_data_i};
            else if (e_hit_rdy) m_wdata <= {bus.hit_offset_i, bus.hit_data_i};
            if (e_miss_rdy || e_hit_rdy) m_last_miss <= e_miss_rdy;
            if (m_wren && !e_ret) m_out <= m_out + 1;
            else if (e_ret && !m_wren) begin
                if (m_out == 0) m_err <= 1;
                else            m_out <= m_out - 1;
            end
            m_done <= (m_mode == 1) && (m_out == 0) && !m_wren;
            if (m_mode == 0 && bus.flush_i) m_mode <= 1;
            else if (m_mode == 1 && m_out == 0 && !m_wren) m_mode <= 2;
            else if (m_mode == 2 && !bus.flush_i) m_mode <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hit_ready",   518'(bus.hit_ready_o),   518'(e_hit_rdy));
            check("miss_ready",  518'(bus.miss_ready_o),  518'(e_miss_rdy));
            check("fifo_wren",   518'(bus.fifo_wren_o),   518'(m_wren));
            check("fifo_wdata",  bus.fifo_wdata_o,        m_wdata);
            check("outstanding", 518'(bus.outstanding_o), 518'(m_out));
            check("err",         518'(bus.err_o),         518'(m_err));
            check("flush_done",  518'(bus.flush_done_o),  518'(m_done));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic ret1();
        bus.rvalid_i = 1; bus.rready_i = 1; bus.rlast_i = 1;
        step();
        bus.rvalid_i = 0; bus.rready_i = 0; bus.rlast_i = 0;
    endtask

    logic [511:0] pk_line;
    int           done_cnt;

    initial begin
        bus.hit_valid_i = 1; bus.hit_offset_i = 6'h08; bus.hit_data_i = mkline(64'hAAAA_0000);
        bus.miss_valid_i = 1; bus.miss_offset_i = 6'h28; bus.miss_data_i = mkline(64'hBBBB_0000);
        bus.fifo_full_i = 0; bus.fifo_afull_i = 0;
        bus.rvalid_i = 0; bus.rready_i = 0; bus.rlast_i = 0; bus.flush_i = 0;

        #3;
        check("rst_hit_ready",  518'(bus.hit_ready_o), 518'(0));
        check("rst_miss_ready", 518'(bus.miss_ready_o), 518'(0));
        check("rst_wren",       518'(bus.fifo_wren_o), 518'(0));
        check("rst_wdata",      bus.fifo_wdata_o, 518'(0));
        check("rst_outstanding", 518'(bus.outstanding_o), 518'(0));
        check("rst_err",        518'(bus.err_o), 518'(0));
        check("rst_flush_done", 518'(bus.flush_done_o), 518'(0));
        step(); step();
        check("rst_ready_held", 518'(bus.miss_ready_o), 518'(0));
        rst_n = 1;
        chk_en = 1;

        // Priority: both valid, four pushes then credit stall
        for (int i = 0; i < 4; i++) begin
            mid();
`ifdef CC_RESP_RR_EN
            check("prio_miss_ready", 518'(bus.miss_ready_o), 518'((i % 2) == 0));
            check("prio_hit_ready",  518'(bus.hit_ready_o),  518'((i % 2) == 1));
`else
            check("prio_miss_ready", 518'(bus.miss_ready_o), 518'(1));
            check("prio_hit_ready",  518'(bus.hit_ready_o),  518'(0));
`endif
            step();
        end
        mid();
        check("credit_stall", 518'(bus.miss_ready_o | bus.hit_ready_o), 518'(0));
        step();
        bus.hit_valid_i = 0;
        mid();
        check("credit_full_count", 518'(bus.outstanding_o), 518'(4));
        check("credit_5th_stall",  518'(bus.miss_ready_o), 518'(0));
        step();
        bus.rvalid_i = 1; bus.rready_i = 1; bus.rlast_i = 1;
        mid();
        check("no_rlast_bypass", 518'(bus.miss_ready_o), 518'(0));
        step();
        bus.rvalid_i = 0; bus.rready_i = 0; bus.rlast_i = 0;
        mid();
        check("credit_returned", 518'(bus.miss_ready_o), 518'(1));
        step();
        bus.miss_valid_i = 0;
        bus.rvalid_i = 1; bus.rready_i = 1; bus.rlast_i = 1;
        step();
        bus.rvalid_i = 0; bus.rready_i = 0; bus.rlast_i = 0;
        mid();
        check("push_and_rlast_same_cycle", 518'(bus.outstanding_o), 518'(3));
        step();
        ret1(); ret1(); ret1();
        mid();
        check("drained_count", 518'(bus.outstanding_o), 518'(0));
        step();

        // Packing: miss offset 0x10, beat k = k
        pk_line = mkline(64'h0);
        bus.miss_offset_i = 6'h10; bus.miss_data_i = pk_line; bus.miss_valid_i = 1;
        step();
        bus.miss_valid_i = 0;
        mid();
        check("pack_wren",   518'(bus.fifo_wren_o), 518'(1));
        check("pack_offset", 518'(bus.fifo_wdata_o[517:512]), 518'(6'h10));
        check("pack_line",   518'(bus.fifo_wdata_o[511:0]), 518'(pk_line));
        step();
        ret1();

        // FIFO pressure
        bus.hit_valid_i = 1; bus.hit_data_i = mkline(64'h100); bus.hit_offset_i = 6'h3C;
        mid();
        check("afull_pre_ready", 518'(bus.hit_ready_o), 518'(1));
        step();
        bus.fifo_afull_i = 1;
        mid();
        check("afull_push_in_progress", 518'(bus.hit_ready_o), 518'(0));
        step();
        mid();
        check("afull_idle_one_allowed", 518'(bus.hit_ready_o), 518'(1));
        step();
        bus.hit_valid_i = 0; bus.fifo_afull_i = 0;
        step();
        bus.fifo_full_i = 1; bus.hit_valid_i = 1;
        mid();
        check("full_blocks", 518'(bus.hit_ready_o), 518'(0));
        step();
        bus.fifo_full_i = 0; bus.hit_valid_i = 0;
        ret1(); ret1();

        // Flush with two lines in flight
        bus.miss_valid_i = 1;
        step(); step();
        bus.flush_i = 1;
        mid();
        check("flush_ready_low", 518'(bus.miss_ready_o), 518'(0));
        step();
        mid();
        check("flush_outstanding", 518'(bus.outstanding_o), 518'(2));
        step();
        ret1(); ret1();
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            mid();
            if (bus.flush_done_o) done_cnt++;
            step();
        end
        check("flush_done_pulses", 518'(done_cnt), 518'(1));
        bus.flush_i = 0;
        step();
        mid();
        check("resume_after_flush", 518'(bus.miss_ready_o), 518'(1));
        step();
        bus.miss_valid_i = 0;
        step();
        ret1();

        // Underflow error
        ret1();
        mid();
        check("err_set",        518'(bus.err_o), 518'(1));
        check("err_count_zero", 518'(bus.outstanding_o), 518'(0));
        step(); step();
        mid();
        check("err_sticky", 518'(bus.err_o), 518'(1));
        step();

        // Asynchronous reset mid-operation
        bus.miss_valid_i = 1; bus.miss_data_i = mkline(64'hC0DE);
        step(); step();
        mid();
        rst_n = 0;
        #1;
        check("arst_wren",        518'(bus.fifo_wren_o), 518'(0));
        check("arst_wdata",       bus.fifo_wdata_o, 518'(0));
        check("arst_outstanding", 518'(bus.outstanding_o), 518'(0));
        check("arst_err",         518'(bus.err_o), 518'(0));
        check("arst_ready",       518'(bus.miss_ready_o), 518'(0));
        step();
        bus.miss_valid_i = 0;
        rst_n = 1;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
